// File: rtl/dma_ram_rd_axis_source.sv
// Segmented DMA RAM reader: fetches one descriptor's byte range through the
// per-segment read command channels, buffers responses in small per-segment
// FWFT FIFOs and emits the data as a single AXI-stream frame, then reports
// completion on the status channel.
// Optional feature macro: DMA_RAM_RD_TID_EN adds m_axis_tid (descriptor tag).
module dma_ram_rd_axis_source #(
    parameter int SEG_COUNT      = 2,
    parameter int SEG_DATA_WIDTH = 128,
    parameter int SEG_ADDR_WIDTH = 8,
    parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8,
    parameter int RAM_ADDR_WIDTH = SEG_ADDR_WIDTH + $clog2(SEG_COUNT * SEG_BE_WIDTH),
    parameter int LEN_WIDTH      = 16,
    parameter int TAG_WIDTH      = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [RAM_ADDR_WIDTH-1:0]           s_axis_desc_ram_addr,
    input  logic [LEN_WIDTH-1:0]                s_axis_desc_len,
    input  logic [TAG_WIDTH-1:0]                s_axis_desc_tag,
    input  logic                                s_axis_desc_valid,
    output logic                                s_axis_desc_ready,
    output logic [TAG_WIDTH-1:0]                m_axis_desc_status_tag,
    output logic                                m_axis_desc_status_error,
    output logic                                m_axis_desc_status_valid,
    output logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] ram_rd_cmd_addr,
    output logic [SEG_COUNT-1:0]                ram_rd_cmd_valid,
    input  logic [SEG_COUNT-1:0]                ram_rd_cmd_ready,
    input  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] ram_rd_resp_data,
    input  logic [SEG_COUNT-1:0]                ram_rd_resp_valid,
    output logic [SEG_COUNT-1:0]                ram_rd_resp_ready,
    output logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [SEG_COUNT*SEG_BE_WIDTH-1:0]   m_axis_tkeep,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
`ifdef DMA_RAM_RD_TID_EN
    output logic [TAG_WIDTH-1:0]                m_axis_tid,
`endif
    output logic                                m_axis_tlast
);

    localparam int GROUP_BYTES = SEG_COUNT * SEG_BE_WIDTH;
    localparam int OFFS_W      = $clog2(GROUP_BYTES);
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = LEN_WIDTH - OFFS_W + 1;

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StStatus} state_e;

    state_e                    state_q, state_d;
    logic                      desc_ready_q;
    logic [TAG_WIDTH-1:0]      tag_q;
    logic                      err_q;
    logic [SEG_ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]          issue_cnt_q;
    logic [CNT_W-1:0]          out_cnt_q;
    logic [OFFS_W-1:0]         rem_q;
    logic [SEG_COUNT-1:0]      cmd_mask_q;
    logic [PTR_W:0]            credit_q, credit_d;

    logic                      desc_accept;
    logic                      desc_bad;
    logic [CNT_W-1:0]          desc_beats;
    logic [SEG_COUNT-1:0]      cmd_hs;
    logic                      beat_issue;
    logic                      credit_ok;
    logic                      pop;
    logic [SEG_COUNT-1:0]      fifo_empty;
    logic [GROUP_BYTES-1:0]    last_keep;

    assign desc_accept = s_axis_desc_valid && desc_ready_q;
    assign desc_bad    = (|s_axis_desc_ram_addr[OFFS_W-1:0]) || (s_axis_desc_len == '0);
    // ceil(len / GROUP_BYTES) without a wide adder
    assign desc_beats  = {1'b0, s_axis_desc_len[LEN_WIDTH-1:OFFS_W]}
                         + CNT_W'(|s_axis_desc_len[OFFS_W-1:0]);

    // Credit limit keeps outstanding beats within FIFO capacity, so FIFOs never overflow
    assign credit_ok        = credit_q < (PTR_W+1)'(FIFO_DEPTH);
    assign ram_rd_cmd_valid = (state_q == StRead && credit_ok) ? ~cmd_mask_q : '0;
    assign ram_rd_cmd_addr  = {SEG_COUNT{addr_q}};
    assign cmd_hs           = ram_rd_cmd_valid & ram_rd_cmd_ready;
    assign beat_issue       = (state_q == StRead) && (&(cmd_mask_q | cmd_hs));

    assign m_axis_tvalid = ~|fifo_empty;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign m_axis_tlast  = out_cnt_q == CNT_W'(1);
    assign last_keep     = (rem_q == '0) ? '1 : (GROUP_BYTES'(1) << rem_q) - GROUP_BYTES'(1);
    assign m_axis_tkeep  = m_axis_tlast ? last_keep : '1;

    assign s_axis_desc_ready        = desc_ready_q;
    assign m_axis_desc_status_valid = state_q == StStatus;
    assign m_axis_desc_status_tag   = tag_q;
    assign m_axis_desc_status_error = err_q;
`ifdef DMA_RAM_RD_TID_EN
    assign m_axis_tid = tag_q;
`endif

    // Per-segment first-word-fall-through response buffers
    for (genvar n = 0; n < SEG_COUNT; n++) begin : g_seg
        logic [SEG_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [PTR_W:0]            wr_ptr_q, rd_ptr_q;
        logic [PTR_W:0]            fill;
        logic                      wr_en;

        assign fill                 = wr_ptr_q - rd_ptr_q;
        assign ram_rd_resp_ready[n] = fill != (PTR_W+1)'(FIFO_DEPTH);
        assign fifo_empty[n]        = wr_ptr_q == rd_ptr_q;
        assign wr_en                = ram_rd_resp_valid[n] && ram_rd_resp_ready[n];
        assign m_axis_tdata[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH] = mem[rd_ptr_q[PTR_W-1:0]];

        // FIFO pointer update
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end

        // FIFO storage write
        always_ff @(posedge clk) begin
            if (wr_en) mem[wr_ptr_q[PTR_W-1:0]] <= ram_rd_resp_data[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH];
        end
    end

    // Next-state logic for the descriptor FSM
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (desc_accept) state_d = desc_bad ? StStatus : StRead;
            StRead:   if (beat_issue && issue_cnt_q == CNT_W'(1)) state_d = StDrain;
            StDrain:  if (pop && m_axis_tlast) state_d = StStatus;
            StStatus: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Credit counter: beats issued to RAM but not yet popped to the stream
    always_comb begin
        credit_d = credit_q;
        if (beat_issue && !pop) credit_d = credit_q + 1'b1;
        else if (!beat_issue && pop) credit_d = credit_q - 1'b1;
    end

    // State, descriptor context and read-issue bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            desc_ready_q <= 1'b0;
            tag_q        <= '0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            issue_cnt_q  <= '0;
            out_cnt_q    <= '0;
            rem_q        <= '0;
            cmd_mask_q   <= '0;
            credit_q     <= '0;
        end else begin
            state_q      <= state_d;
            desc_ready_q <= state_d == StIdle;
            credit_q     <= credit_d;
            if (desc_accept) begin
                tag_q       <= s_axis_desc_tag;
                err_q       <= desc_bad;
                addr_q      <= s_axis_desc_ram_addr[RAM_ADDR_WIDTH-1:OFFS_W];
                issue_cnt_q <= desc_beats;
                out_cnt_q   <= desc_beats;
                rem_q       <= s_axis_desc_len[OFFS_W-1:0];
                cmd_mask_q  <= '0;
            end else if (state_q == StRead) begin
                if (beat_issue) begin
                    cmd_mask_q  <= '0;
                    addr_q      <= addr_q + 1'b1;
                    issue_cnt_q <= issue_cnt_q - 1'b1;
                end else begin
                    cmd_mask_q <= cmd_mask_q | cmd_hs;
                end
            end
            if (pop) out_cnt_q <= out_cnt_q - 1'b1;
        end
    end

endmodule
